// File: rtl/pin_freq_meter.sv
// pin_freq_meter: counts rising edges of an asynchronous pin over a fixed
// gate window of GATE_CYCLES clk cycles and publishes the count once per
// window. Defining PIN_FREQ_METER_PERIOD_EN adds a period measurement
// (clk cycles between the last two rising edges); without it the period
// outputs are tied to zero but stay on the port list.
module pin_freq_meter #(
    parameter int GATE_CYCLES = 1000000,
    parameter int COUNT_W     = 24,
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_in,
    output logic [COUNT_W-1:0]  freq_count,
    output logic                freq_valid,
    output logic                freq_ovf,
    output logic [PERIOD_W-1:0] period_cycles,
    output logic                period_valid
);

    localparam int                 GATE_W     = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES + 1);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [0:0]             r_state;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic [GATE_W-1:0]      r_gate_cnt;
    logic [COUNT_W-1:0]     r_edge_cnt;
    logic                   r_sat;
    logic [COUNT_W-1:0]     r_freq_count;
    logic                   r_freq_valid;
    logic                   r_freq_ovf;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_run;
    logic                   w_rise_run;
    logic                   w_edge_max;
    logic [COUNT_W-1:0]     w_close_count;
    logic                   w_close_clip;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_s_d;
    assign w_run      = (r_state == ST_RUN);
    assign w_rise_run = w_rise & w_run;
    assign w_edge_max = &r_edge_cnt;

    // Synchronizer chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops
        // sample the pre-edge values, which is what makes the chain a chain.
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d  <= w_s;
        end
    end

    // Edge count after this cycle's rise, saturating; clip marks a lost edge.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        w_close_count = r_edge_cnt;
        w_close_clip  = 1'b0;
        if (w_rise_run) begin
            if (w_edge_max) begin
                w_close_clip = 1'b1;
            end else begin
                w_close_count = r_edge_cnt + 1'b1;
            end
        end
    end

    // FLUSH/RUN control, gate window, edge counter and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FLUSH;
            r_flush_cnt  <= '0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            r_freq_count <= '0;
            r_freq_valid <= 1'b0;
            r_freq_ovf   <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            if (r_state == ST_FLUSH) begin
                // Let the synchronizer settle; edges seen here are stale.
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
                if (r_flush_cnt == FLUSH_LAST) begin
                    r_state <= ST_RUN;
                end else begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end else begin
                if (r_gate_cnt == GATE_LAST) begin
                    // A rise in the last cycle still belongs to this window.
                    r_gate_cnt   <= '0;
                    r_edge_cnt   <= '0;
                    r_sat        <= 1'b0;
                    r_freq_count <= w_close_count;
                    r_freq_ovf   <= r_sat | w_close_clip;
                    r_freq_valid <= 1'b1;
                end else begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    r_edge_cnt <= w_close_count;
                    r_sat      <= r_sat | w_close_clip;
                end
            end
        end
    end

    assign freq_count = r_freq_count;
    assign freq_valid = r_freq_valid;
    assign freq_ovf   = r_freq_ovf;

`ifdef PIN_FREQ_METER_PERIOD_EN
    logic [PERIOD_W-1:0] r_per_cnt;
    logic [PERIOD_W-1:0] r_period_cycles;
    logic                r_period_valid;
    logic                r_armed;
    logic [PERIOD_W-1:0] w_per_next;

    // Saturating increment; all-ones means timeout or too-slow input.
    assign w_per_next = (&r_per_cnt) ? r_per_cnt : r_per_cnt + 1'b1;

    // Period counter: the first rise only arms, later rises publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt       <= '0;
            r_period_cycles <= '0;
            r_period_valid  <= 1'b0;
            r_armed         <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_run) begin
                if (w_rise) begin
                    r_per_cnt <= '0;
                    r_armed   <= 1'b1;
                    if (r_armed) begin
                        r_period_cycles <= w_per_next;
                        r_period_valid  <= 1'b1;
                    end
                end else begin
                    r_per_cnt <= w_per_next;
                end
            end
        end
    end

    assign period_cycles = r_period_cycles;
    assign period_valid  = r_period_valid;
`else
    assign period_cycles = '0;
    assign period_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pin_freq_meter.sv
// Bench for pin_freq_meter: two instances (COUNT_W=8 and COUNT_W=4,
// GATE_CYCLES=100) watch the same pin. A background generator drives a
// square wave or a constant level; directed vectors check steady windows,
// hand sequences check reset timing, the last-cycle edge and mid-window
// reset.
module tb_pin_freq_meter;

    localparam int GATE = 100;
    localparam int SYNC = 2;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic [7:0]  c8;
    logic        v8;
    logic        o8;
    logic [23:0] p8;
    logic        pv8;
    logic [3:0]  c4;
    logic        v4;
    logic        o4;
    logic [3:0]  p4;
    logic        pv4;

    pin_freq_meter #(
        .GATE_CYCLES(GATE), .COUNT_W(8), .SYNC_STAGES(SYNC), .PERIOD_W(24)
    ) dut8 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .freq_count(c8), .freq_valid(v8), .freq_ovf(o8),
        .period_cycles(p8), .period_valid(pv8)
    );

    pin_freq_meter #(
        .GATE_CYCLES(GATE), .COUNT_W(4), .SYNC_STAGES(SYNC), .PERIOD_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .freq_count(c4), .freq_valid(v4), .freq_ovf(o4),
        .period_cycles(p4), .period_valid(pv4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pin generator: half==0 holds wave_level, else toggles every half cycles.
    int   wave_half  = 0;
    logic wave_level = 1'b1;
    int   wave_ph    = 0;

    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wave_half == 0) begin
                sig_in  = wave_level;
                wave_ph = 0;
            end else begin
                wave_ph++;
                if (wave_ph >= wave_half) begin
                    wave_ph = 0;
                    sig_in  = ~sig_in;
                end
            end
        end
    end

    // Results may only move with a valid pulse; valid is a single cycle.
    int         hold_err = 0;
    int         pv_seen  = 0;
    logic       rst_at_edge;
    logic [7:0] prev_c8 = '0;
    logic [3:0] prev_c4 = '0;
    logic       prev_o8 = 1'b0;
    logic       prev_o4 = 1'b0;
    logic       prev_v8 = 1'b0;

    always @(posedge clk) begin
        rst_at_edge = rst;
        #2;
        if (!rst_at_edge) begin
            if (!v8 && (c8 !== prev_c8 || o8 !== prev_o8)) hold_err++;
            if (!v4 && (c4 !== prev_c4 || o4 !== prev_o4)) hold_err++;
            if (v8 && prev_v8) hold_err++;
            if (v8 !== v4) hold_err++;
        end
        if (pv8 || pv4) pv_seen++;
        prev_c8 = c8;
        prev_c4 = c4;
        prev_o8 = o8;
        prev_o4 = o4;
        prev_v8 = v8;
    end

    // Wait for the next freq_valid, sampled on negedges; -1 on timeout.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (v8) return;
        end
        cycles = -1;
    endtask

    typedef struct {
        string name;
        int    half;
        logic  level;
        int    exp_c8;
        logic  exp_o8;
        int    exp_c4;
        logic  exp_o4;
    } vec_t;

    vec_t vecs[10];
    int   cyc;
    int   cnt;

    initial begin
        vecs[0] = '{"low",      0, 1'b0,  0, 1'b0,  0, 1'b0};
        vecs[1] = '{"high",     0, 1'b1,  0, 1'b0,  0, 1'b0};
        vecs[2] = '{"per10",    5, 1'b0, 10, 1'b0, 10, 1'b0};
        vecs[3] = '{"per4",     2, 1'b0, 25, 1'b0, 15, 1'b1};
        vecs[4] = '{"stopped",  0, 1'b0,  0, 1'b0,  0, 1'b0};
        vecs[5] = '{"per2",     1, 1'b0, 50, 1'b0, 15, 1'b1};
        vecs[6] = '{"per20",   10, 1'b0,  5, 1'b0,  5, 1'b0};
        vecs[7] = '{"per50",   25, 1'b0,  2, 1'b0,  2, 1'b0};
        vecs[8] = '{"per100",  50, 1'b0,  1, 1'b0,  1, 1'b0};
        vecs[9] = '{"low_end",  0, 1'b0,  0, 1'b0,  0, 1'b0};

        // Reset with the pin already high: no phantom edge allowed.
        rst        = 1'b1;
        wave_half  = 0;
        wave_level = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_freq_count", c8, 0);
        check("rst_freq_valid", v8, 0);
        check("rst_freq_ovf", o8, 0);
        check("rst_count4", c4, 0);
        check("rst_period_cycles", p8, 0);
        check("rst_period_valid", pv8, 0);
        rst = 1'b0;
        wait_valid(300, cyc);
        check("first_valid_latency", cyc, SYNC + 1 + GATE + 1);
        check("high_from_reset_c8", c8, 0);
        check("high_from_reset_o8", o8, 0);
        check("high_from_reset_c4", c4, 0);

        // Steady-state windows: switch pattern, discard one window, check.
        for (int i = 0; i < 10; i++) begin
            wave_half  = vecs[i].half;
            wave_level = vecs[i].level;
            wait_valid(150, cyc);
            wait_valid(150, cyc);
            check($sformatf("%s_spacing", vecs[i].name), cyc, GATE);
            check($sformatf("%s_c8", vecs[i].name), c8, vecs[i].exp_c8);
            check($sformatf("%s_o8", vecs[i].name), o8, vecs[i].exp_o8);
            check($sformatf("%s_c4", vecs[i].name), c4, vecs[i].exp_c4);
            check($sformatf("%s_o4", vecs[i].name), o4, vecs[i].exp_o4);
            check($sformatf("%s_v4", vecs[i].name), v4, 1);
        end

        // Single rise timed to land on the last gate cycle (gate_cnt 99).
        repeat (GATE - SYNC - 2) @(negedge clk);
        wave_level = 1'b1;
        wait_valid(150, cyc);
        check("last_cycle_spacing", cyc, SYNC + 2);
        check("last_cycle_c8", c8, 1);
        check("last_cycle_o8", o8, 0);
        check("last_cycle_c4", c4, 1);
        wait_valid(150, cyc);
        check("after_last_cycle_c8", c8, 0);

        // One-cycle reset at gate_cnt 50 with a 10-cycle square wave.
        wave_half = 5;
        wait_valid(150, cyc);
        wait_valid(150, cyc);
        check("pre_reset_c8", c8, 10);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_c8", c8, 0);
        check("mid_reset_valid", v8, 0);
        rst = 1'b0;
        wait_valid(300, cyc);
        check("mid_reset_relatency", cyc, SYNC + 1 + GATE + 1);
        check("mid_reset_c8", c8, 10);
        check("mid_reset_o8", o8, 0);

`ifdef PIN_FREQ_METER_PERIOD_EN
        // First rise after reset only arms the period counter.
        wave_half  = 0;
        wave_level = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_valid(300, cyc);
        wave_half = 5;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pv8) cnt++;
        end
        check("period_arm_pulses", cnt, 2);
        check("period_10_p8", p8, 10);
        check("period_10_p4", p4, 10);
        wave_half = 20;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            while (cnt < 200 && !pv8) begin
                @(negedge clk);
                cnt++;
            end
            if (k < 2) @(negedge clk);
        end
        check("period_40_p8", p8, 40);
        check("period_40_p4", p4, 15);
        wave_half = 0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (pv8) cnt++;
        end
        check("period_stop_pulses", cnt, 0);
        check("period_stop_hold", p8, 40);
`else
        check("period_valid_never", pv_seen, 0);
        check("period_tied_p8", p8, 0);
        check("period_tied_p4", p4, 0);
`endif

        check("hold_and_pulse_errors", hold_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
